// File: rtl/psum_collector.sv
// ---------------------------------------------------------------------------
// psum_collector
//
// Sink at the bottom edge of the systolic PE array. The bottom row emits its
// psums skewed in time: column j of a row appears j cycles after column 0.
// This block re-aligns every row, queues complete rows in a small
// first-word-fall-through FIFO, and hands them to the writeback logic on a
// valid/ready stream.
//
// Ports
//   CLK       in   1                clock, rising edge
//   RST       in   1                synchronous reset, active-low
//   ColValid  in   1                column-0 psum of a new row valid this cycle
//   PsumIn    in   COLS*2*WIDTH     bottom-row psums, col j at [j*2W +: 2W]
//   OutReady  in   1                downstream accepts OutData
//   OutValid  out  1                OutData holds a complete aligned row
//   OutData   out  COLS*2*WIDTH     aligned row, col 0 at LSBs
//   Count     out  $clog2(DEPTH)+1  rows currently held in the FIFO
//   Full      out  1                Count == DEPTH
//   Overflow  out  1                sticky: a completed row was dropped
//
// Handshake: a row transfers on every rising edge where OutValid && OutReady.
// OutValid never depends on OutReady, and once OutValid is high OutData holds
// its value until that transfer happens. The array side has no backpressure:
// an aligned row that arrives while the FIFO is full and nothing is popped
// on that edge is dropped and Overflow is set until the next reset.
// ---------------------------------------------------------------------------
module psum_collector #(
    parameter int WIDTH = 8,
    parameter int COLS  = 4,
    parameter int DEPTH = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        ColValid,
    input  logic [COLS*2*WIDTH-1:0]     PsumIn,
    input  logic                        OutReady,
    output logic                        OutValid,
    output logic [COLS*2*WIDTH-1:0]     OutData,
    output logic [$clog2(DEPTH):0]      Count,
    output logic                        Full,
    output logic                        Overflow
);

    localparam int PW = 2 * WIDTH;          // one psum
    localparam int RW = COLS * PW;          // one row
    localparam int AW = $clog2(DEPTH);      // FIFO pointer width
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    // -----------------------------------------------------------------------
    // De-skew
    // -----------------------------------------------------------------------
    // ColValid travels down a COLS-1 stage chain; its last stage is high on
    // the cycle in which the final column of the marked row is on PsumIn.
    logic [COLS-2:0] vchain;
    logic            aligned_valid;
    logic [RW-1:0]   aligned_row;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            vchain <= '0;
        end else begin
            vchain[0] <= ColValid;
            for (int k = 1; k < COLS - 1; k++) begin
                vchain[k] <= vchain[k-1];
            end
        end
    end

    assign aligned_valid = vchain[COLS-2];

    // Column j arrives j cycles late, so it only needs COLS-1-j stages of
    // delay to line up with the last column. The last column needs none and
    // is taken straight from the input.
    for (genvar j = 0; j < COLS - 1; j++) begin : g_col
        localparam int N = COLS - 1 - j;
        logic [PW-1:0] sr [N];

        always_ff @(posedge CLK) begin
            if (!RST) begin
                for (int k = 0; k < N; k++) begin
                    sr[k] <= '0;
                end
            end else begin
                sr[0] <= PsumIn[j*PW +: PW];
                for (int k = 1; k < N; k++) begin
                    sr[k] <= sr[k-1];
                end
            end
        end

        assign aligned_row[j*PW +: PW] = sr[N-1];
    end

    assign aligned_row[(COLS-1)*PW +: PW] = PsumIn[(COLS-1)*PW +: PW];

    // -----------------------------------------------------------------------
    // Output FIFO (first-word-fall-through)
    // -----------------------------------------------------------------------
    logic [RW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic          overflow_q;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          drop;

    assign full    = (count_q == FULL_CNT);
    assign pop     = OutValid && OutReady;
    // When full, a pop on the same edge frees the slot being written: with a
    // full FIFO wr_ptr equals rd_ptr, and that head row leaves on this edge.
    assign push_ok = aligned_valid && (!full || pop);
    assign drop    = aligned_valid && full && !pop;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            // Storage is cleared so OutData reads 0 straight after reset.
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= aligned_row;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push_ok) begin
                count_q <= count_q - 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign OutValid = (count_q != '0);
    assign OutData  = mem[rd_ptr];
    assign Count    = count_q;
    assign Full     = full;
    assign Overflow = overflow_q;

endmodule

// File: tb/tb_psum_collector.sv
// ---------------------------------------------------------------------------
// tb_psum_collector
//
// Bench for psum_collector at WIDTH=8, COLS=4, DEPTH=4. A short table of
// hand-derived vectors covers the single-row case; hand-written sequences
// cover streaming, overflow, full push+pop, reset mid-row and extreme
// values; a random phase closes out. Expected rows come from a reference
// model that keeps the raw input history per cycle and assembles each row
// from the cycles its columns were sampled in, feeding a queue of rows.
// ---------------------------------------------------------------------------
module tb_psum_collector;

    localparam int WIDTH = 8;
    localparam int COLS  = 4;
    localparam int DEPTH = 4;
    localparam int PW    = 2 * WIDTH;
    localparam int RW    = COLS * PW;
    localparam int HIST  = 4096;

    // -----------------------------------------------------------------------
    // Clock / reset / DUT
    // -----------------------------------------------------------------------
    logic          CLK = 1'b0;
    logic          RST;
    logic          ColValid;
    logic [RW-1:0] PsumIn;
    logic          OutReady;
    logic          OutValid;
    logic [RW-1:0] OutData;
    logic [2:0]    Count;
    logic          Full;
    logic          Overflow;

    always #5 CLK = ~CLK;

    psum_collector #(.WIDTH(WIDTH), .COLS(COLS), .DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .ColValid (ColValid),
        .PsumIn   (PsumIn),
        .OutReady (OutReady),
        .OutValid (OutValid),
        .OutData  (OutData),
        .Count    (Count),
        .Full     (Full),
        .Overflow (Overflow)
    );

    // -----------------------------------------------------------------------
    // Reference model / scoreboard
    // -----------------------------------------------------------------------
    int            n_vec = 0;
    int            n_err = 0;
    logic [RW-1:0] exp_q[$];
    bit            m_ovf = 1'b0;
    int            cyc = 0;
    int            last_rst = -1;
    bit            cv_hist [HIST];
    logic [RW-1:0] ps_hist [HIST];

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One rising edge of the reference model. A row marked at cycle t is
    // made of column j sampled at cycle t+j and becomes available at cycle
    // t+COLS-1, unless a reset edge occurred at or after t.
    task automatic model_edge(input bit cv, input logic [RW-1:0] ps, input bit rdy, input bit rst);
        logic [RW-1:0] row;
        bit            push;
        bit            pop;
        bit            was_full;
        int            t;
        cv_hist[cyc] = cv;
        ps_hist[cyc] = ps;
        if (!rst) begin
            exp_q.delete();
            m_ovf    = 1'b0;
            last_rst = cyc;
        end else begin
            t    = cyc - (COLS - 1);
            push = (t >= 0) && (t > last_rst) && cv_hist[t];
            row  = '0;
            if (push) begin
                for (int j = 0; j < COLS; j++) begin
                    row[j*PW +: PW] = ps_hist[t+j][j*PW +: PW];
                end
            end
            was_full = (exp_q.size() == DEPTH);
            pop      = (exp_q.size() > 0) && rdy;
            if (pop) void'(exp_q.pop_front());
            if (push) begin
                if (was_full && !pop) m_ovf = 1'b1;
                else exp_q.push_back(row);
            end
        end
        cyc++;
    endtask

    // -----------------------------------------------------------------------
    // Driver: inputs change at the falling edge, outputs are read there too
    // -----------------------------------------------------------------------
    task automatic drive(input bit cv, input logic [RW-1:0] ps, input bit rdy, input bit rst);
        ColValid = cv;
        PsumIn   = ps;
        OutReady = rdy;
        RST      = rst;
        @(posedge CLK);
        model_edge(cv, ps, rdy, rst);
        @(negedge CLK);
    endtask

    task automatic check_model(input string tag);
        chk({tag, " valid"},    OutValid, exp_q.size() > 0);
        chk({tag, " count"},    Count,    exp_q.size());
        chk({tag, " full"},     Full,     exp_q.size() == DEPTH);
        chk({tag, " overflow"}, Overflow, m_ovf);
        if (exp_q.size() > 0) chk({tag, " data"}, OutData, exp_q[0]);
    endtask

    function automatic logic [RW-1:0] rand_ps();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [RW-1:0] extreme_ps();
        logic [RW-1:0] p;
        for (int j = 0; j < COLS; j++) begin
            p[j*PW +: PW] = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0000;
        end
        return p;
    endfunction

    // -----------------------------------------------------------------------
    // Single-row table
    // -----------------------------------------------------------------------
    typedef struct {
        bit            cv;
        logic [RW-1:0] ps;
        bit            rdy;
        bit            e_valid;
        bit            chk_data;
        logic [RW-1:0] e_data;
        logic [2:0]    e_count;
        bit            e_full;
        bit            e_ovf;
    } vec_t;

    vec_t tbl [5];

    task automatic do_reset();
        drive(1'b0, '0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [RW-1:0] row1;
        row1   = {16'd400, 16'd300, 16'd200, 16'd100};
        tbl[0] = '{1'b1, {16'd0,   16'd0,   16'd0,   16'd100}, 1'b0, 1'b0, 1'b0, '0,   3'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, {16'd0,   16'd0,   16'd200, 16'd0},   1'b0, 1'b0, 1'b0, '0,   3'd0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, {16'd0,   16'd300, 16'd0,   16'd0},   1'b0, 1'b0, 1'b0, '0,   3'd0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, {16'd400, 16'd0,   16'd0,   16'd0},   1'b0, 1'b1, 1'b1, row1, 3'd1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, '0,                                   1'b1, 1'b0, 1'b0, '0,   3'd0, 1'b0, 1'b0};

        ColValid = 1'b0;
        PsumIn   = '0;
        OutReady = 1'b0;
        RST      = 1'b0;
        @(negedge CLK);

        // Reset state
        do_reset();
        chk("rst valid",    OutValid, 1'b0);
        chk("rst data",     OutData,  '0);
        chk("rst count",    Count,    3'd0);
        chk("rst full",     Full,     1'b0);
        chk("rst overflow", Overflow, 1'b0);

        // Single row from the table
        for (int i = 0; i < 5; i++) begin
            drive(tbl[i].cv, tbl[i].ps, tbl[i].rdy, 1'b1);
            chk($sformatf("row1[%0d] valid", i),    OutValid, tbl[i].e_valid);
            chk($sformatf("row1[%0d] count", i),    Count,    tbl[i].e_count);
            chk($sformatf("row1[%0d] full", i),     Full,     tbl[i].e_full);
            chk($sformatf("row1[%0d] overflow", i), Overflow, tbl[i].e_ovf);
            if (tbl[i].chk_data) chk($sformatf("row1[%0d] data", i), OutData, tbl[i].e_data);
        end

        // Streaming: three back-to-back rows with the sink always ready
        for (int i = 0; i < 10; i++) begin
            drive(i < 3, rand_ps(), 1'b1, 1'b1);
            check_model("stream");
        end
        chk("stream overflow", Overflow, 1'b0);

        // Overflow: five rows into a stalled sink, then drain
        for (int i = 0; i < 9; i++) begin
            drive(i < 5, rand_ps(), 1'b0, 1'b1);
            check_model("ovf fill");
        end
        chk("ovf count",  Count,    3'd4);
        chk("ovf full",   Full,     1'b1);
        chk("ovf sticky", Overflow, 1'b1);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, rand_ps(), 1'b1, 1'b1);
            check_model("ovf drain");
        end
        chk("ovf after drain", Overflow, 1'b1);

        // Full FIFO with a pop on the same edge as a push
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(i < 5, rand_ps(), i == 7, 1'b1);
            check_model("fullpp");
        end
        chk("fullpp count",    Count,    3'd4);
        chk("fullpp overflow", Overflow, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, rand_ps(), 1'b1, 1'b1);
            check_model("fullpp drain");
        end

        // Reset while a row is half sampled
        drive(1'b1, rand_ps(), 1'b1, 1'b1);
        drive(1'b0, rand_ps(), 1'b1, 1'b1);
        drive(1'b0, rand_ps(), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, rand_ps(), 1'b0, 1'b1);
            chk("midrst valid",    OutValid, 1'b0);
            chk("midrst count",    Count,    3'd0);
            chk("midrst overflow", Overflow, 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            drive(i == 0, rand_ps(), i == 5, 1'b1);
            check_model("midrst next");
        end

        // All-ones / all-zeros psums
        for (int i = 0; i < 12; i++) begin
            drive(i < 4, extreme_ps(), i >= 6, 1'b1);
            check_model("extreme");
        end

        // Random traffic with varying sink readiness and rare resets
        for (int seg = 0; seg < 8; seg++) begin
            int rdy_pct;
            rdy_pct = $urandom_range(10, 100);
            for (int i = 0; i < 50; i++) begin
                drive($urandom_range(0, 2) != 0, rand_ps(),
                      $urandom_range(1, 100) <= rdy_pct,
                      $urandom_range(0, 99) != 0);
                check_model("random");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
